unidade_controle_rodadas: RTL and testbench

Parametrised successor to the single-round game control unit. Sequences a multi-round memory game: round r requires r+1 correct plays (addresses 0..r) before advancing. Adds an internal round counter and a per-play timeout. Sits beside the existing datapath, driving its address counter and play register and reading back address and compare status.

---
 rtl/unidade_controle_rodadas.sv | 98 +++++++++
 tb/tb_unidade_controle_rodadas.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: multi-round memory game control unit (optional play timeout via UC_TIMEOUT_EN)
module unidade_controle_rodadas #(
  parameter int ADDR_W         = 4,
  parameter int NUM_ROUNDS     = 16,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  input  logic [ADDR_W-1:0] endereco,
  output logic              zeraC,
  output logic              contaC,
  output logic              zeraR,
  output logic              registraR,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [ADDR_W-1:0] db_rodada,
  output logic [3:0]        db_estado
);
  typedef enum logic [3:0] {
    INICIAL        = 4'b0000,
    PREPARACAO     = 4'b0001,
    INICIA_RODADA  = 4'b0010,
    ESPERA         = 4'b0011,
    REGISTRA       = 4'b0100,
    COMPARACAO     = 4'b0101,
    PROXIMO        = 4'b0110,
    PROXIMA_RODADA = 4'b0111,
    FINAL_ACERTO   = 4'b1010,
    FINAL_TIMEOUT  = 4'b1101,
    FINAL_ERRO     = 4'b1110
  } estado_t;
  localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(NUM_ROUNDS - 1);
  if (TIMEOUT_CYCLES < 2 || NUM_ROUNDS < 1 || NUM_ROUNDS > 2**ADDR_W) begin : g_param_invalido
    $error("unidade_controle_rodadas: parametros fora da faixa");
  end
  estado_t estado, proximo_estado;
  logic [ADDR_W-1:0] rodada;
  logic fim_tempo;
`ifdef UC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;
  always_ff @(posedge clock or negedge reset)
    if (!reset) timer <= '0;
    else timer <= (estado == ESPERA) ? timer + 1'b1 : '0;
  // espera always exits once the timer reaches its last value, so it never wraps
  assign fim_tempo = timer == TW'(TIMEOUT_CYCLES - 1);
`else
  assign fim_tempo = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) estado <= INICIAL;
    else estado <= proximo_estado;
  // cleared on entry to preparacao so the new game already shows round 0 there
  always_ff @(posedge clock or negedge reset)
    if (!reset) rodada <= '0;
    else if (proximo_estado == PREPARACAO) rodada <= '0;
    else if (estado == PROXIMA_RODADA) rodada <= rodada + 1'b1;
  always_comb begin
    proximo_estado = INICIAL;
    case (estado)
      INICIAL:        proximo_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo_estado = INICIA_RODADA;
      INICIA_RODADA:  proximo_estado = ESPERA;
      ESPERA:         proximo_estado = jogada ? REGISTRA : fim_tempo ? FINAL_TIMEOUT : ESPERA;
      REGISTRA:       proximo_estado = COMPARACAO;
      COMPARACAO:     proximo_estado = !igual ? FINAL_ERRO :
                                       endereco != rodada ? PROXIMO :
                                       rodada == ULTIMA ? FINAL_ACERTO : PROXIMA_RODADA;
      PROXIMO:        proximo_estado = ESPERA;
      PROXIMA_RODADA: proximo_estado = INICIA_RODADA;
      FINAL_ACERTO:   proximo_estado = iniciar ? PREPARACAO : FINAL_ACERTO;
      FINAL_ERRO:     proximo_estado = iniciar ? PREPARACAO : FINAL_ERRO;
`ifdef UC_TIMEOUT_EN
      FINAL_TIMEOUT:  proximo_estado = iniciar ? PREPARACAO : FINAL_TIMEOUT;
`endif
      default:        proximo_estado = INICIAL;
    endcase
  end
  assign zeraC     = estado == PREPARACAO || estado == INICIA_RODADA;
  assign zeraR     = estado == PREPARACAO;
  assign registraR = estado == REGISTRA;
  assign contaC    = estado == PROXIMO;
  assign acertou   = estado == FINAL_ACERTO;
  assign errou     = estado == FINAL_ERRO;
`ifdef UC_TIMEOUT_EN
  assign timeout   = estado == FINAL_TIMEOUT;
`else
  assign timeout   = 1'b0;
`endif
  assign pronto    = acertou || errou || timeout;
  assign db_rodada = rodada;
  assign db_estado = estado;
endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// tb_unidade_controle_rodadas: directed vectors and game sequences for unidade_controle_rodadas
module tb_unidade_controle_rodadas;
  logic clock, reset, iniciar, jogada, igual;
  logic [1:0] endereco;
  logic zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto;
  logic [1:0] db_rodada;
  logic [3:0] db_estado;
  logic [7:0] outs;
  int checks = 0;
  int errors = 0;
  unidade_controle_rodadas #(.ADDR_W(2), .NUM_ROUNDS(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .endereco(endereco), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
    .db_rodada(db_rodada), .db_estado(db_estado)
  );
  assign outs = {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // stand-in for the datapath address counter
  always @(posedge clock or negedge reset)
    if (!reset) endereco <= '0;
    else if (zeraC) endereco <= '0;
    else if (contaC) endereco <= endereco + 1'b1;
  // expected {zeraC,contaC,zeraR,registraR,acertou,errou,timeout,pronto} per state code
  function automatic logic [7:0] exp_outs(input logic [3:0] est);
    case (est)
      4'b0001: return 8'b1010_0000;
      4'b0010: return 8'b1000_0000;
      4'b0100: return 8'b0001_0000;
      4'b0110: return 8'b0100_0000;
      4'b1010: return 8'b0000_1001;
      4'b1101: return 8'b0000_0011;
      4'b1110: return 8'b0000_0101;
      default: return 8'b0000_0000;
    endcase
  endfunction
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [3:0] est, input logic [1:0] rod);
    checks++;
    if (db_estado !== est || db_rodada !== rod || outs !== exp_outs(est)) begin
      errors++;
      $display("FAIL %s: estado=%b rodada=%0d saidas=%b, esperado estado=%b rodada=%0d saidas=%b",
               nm, db_estado, db_rodada, outs, est, rod, exp_outs(est));
    end
  endtask
  // starts in inicia_rodada of round r; plays r+1 correct values
  task automatic round(input int r);
    cyc(); chk("espera", 4'b0011, 2'(r));
    for (int p = 0; p <= r; p++) begin
      jogada = 1'b1; igual = 1'b1;
      cyc(); jogada = 1'b0; chk("registra", 4'b0100, 2'(r));
      cyc(); chk("comparacao", 4'b0101, 2'(r));
      cyc();
      if (p < r) begin
        chk("proximo", 4'b0110, 2'(r));
        cyc(); chk("espera_prox", 4'b0011, 2'(r));
      end else if (r == 3) chk("final_acerto", 4'b1010, 2'd3);
      else begin
        chk("proxima_rodada", 4'b0111, 2'(r));
        cyc(); chk("inicia_rodada", 4'b0010, 2'(r + 1));
      end
    end
  endtask
  typedef struct {
    logic ini, jog, ig;
    logic [3:0] est;
    logic [1:0] rod;
  } vec_t;
  vec_t tab[17];
  initial begin
    tab = '{
      '{1'b1, 1'b0, 1'b1, 4'b0001, 2'd0},
      '{1'b0, 1'b0, 1'b1, 4'b0010, 2'd0},
      '{1'b0, 1'b0, 1'b1, 4'b0011, 2'd0},
      '{1'b0, 1'b1, 1'b1, 4'b0100, 2'd0},
      '{1'b1, 1'b0, 1'b1, 4'b0101, 2'd0},
      '{1'b0, 1'b1, 1'b1, 4'b0111, 2'd0},
      '{1'b0, 1'b0, 1'b1, 4'b0010, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0011, 2'd1},
      '{1'b0, 1'b1, 1'b1, 4'b0100, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0101, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0110, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0011, 2'd1},
      '{1'b0, 1'b1, 1'b1, 4'b0100, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0101, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0111, 2'd1},
      '{1'b0, 1'b0, 1'b1, 4'b0010, 2'd2},
      '{1'b0, 1'b0, 1'b1, 4'b0011, 2'd2}
    };
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b1;
    #3 chk("reset", 4'b0000, 2'd0);
    @(negedge clock) reset = 1'b1;
    cyc(); chk("inicial_hold", 4'b0000, 2'd0);
    for (int i = 0; i < 17; i++) begin
      iniciar = tab[i].ini; jogada = tab[i].jog; igual = tab[i].ig;
      cyc(); chk($sformatf("vetor%0d", i), tab[i].est, tab[i].rod);
    end
    jogada = 1'b0;
    iniciar = 1'b1; cyc(); iniciar = 1'b0; chk("iniciar_em_espera", 4'b0011, 2'd2);
    jogada = 1'b1; cyc(); jogada = 1'b0; chk("erro_registra0", 4'b0100, 2'd2);
    cyc(); chk("erro_comparacao0", 4'b0101, 2'd2);
    cyc(); chk("erro_proximo", 4'b0110, 2'd2);
    cyc(); chk("erro_espera1", 4'b0011, 2'd2);
    jogada = 1'b1; igual = 1'b0; cyc(); jogada = 1'b0; chk("erro_registra1", 4'b0100, 2'd2);
    cyc(); chk("erro_comparacao1", 4'b0101, 2'd2);
    cyc(); chk("final_erro", 4'b1110, 2'd2);
    cyc(); chk("final_erro_hold", 4'b1110, 2'd2);
    igual = 1'b1; iniciar = 1'b1; cyc(); iniciar = 1'b0; chk("reinicio_prep", 4'b0001, 2'd0);
    cyc(); chk("vitoria_inicia", 4'b0010, 2'd0);
    for (int r = 0; r < 4; r++) round(r);
    cyc(); chk("final_acerto_hold", 4'b1010, 2'd3);
    iniciar = 1'b1; cyc(); iniciar = 1'b0; chk("jogo3_prep", 4'b0001, 2'd0);
    cyc(); chk("jogo3_inicia", 4'b0010, 2'd0);
    round(0); round(1);
    cyc(); chk("jogo3_espera_r2", 4'b0011, 2'd2);
    #2 reset = 1'b0;
    #1 chk("reset_assincrono", 4'b0000, 2'd0);
    @(negedge clock) reset = 1'b1;
    cyc(); chk("pos_reset", 4'b0000, 2'd0);
    iniciar = 1'b1; cyc(); iniciar = 1'b0; chk("jogo4_prep", 4'b0001, 2'd0);
    cyc(); chk("jogo4_inicia", 4'b0010, 2'd0);
    cyc(); chk("jogo4_espera_c1", 4'b0011, 2'd0);
`ifdef UC_TIMEOUT_EN
    repeat (7) cyc();
    chk("espera_c8", 4'b0011, 2'd0);
    jogada = 1'b1; cyc(); jogada = 1'b0; chk("jogada_vence_timeout", 4'b0100, 2'd0);
    cyc(); chk("to_comparacao", 4'b0101, 2'd0);
    cyc(); chk("to_proxima_rodada", 4'b0111, 2'd0);
    cyc(); chk("to_inicia_rodada", 4'b0010, 2'd1);
    cyc(); chk("to_espera_c1", 4'b0011, 2'd1);
    for (int c = 2; c <= 8; c++) begin
      cyc(); chk($sformatf("to_espera_c%0d", c), 4'b0011, 2'd1);
    end
    cyc(); chk("final_timeout", 4'b1101, 2'd1);
    cyc(); chk("final_timeout_hold", 4'b1101, 2'd1);
    iniciar = 1'b1; cyc(); iniciar = 1'b0; chk("to_reinicio", 4'b0001, 2'd0);
`else
    repeat (100) cyc();
    chk("sem_timeout_espera", 4'b0011, 2'd0);
    jogada = 1'b1; cyc(); jogada = 1'b0; chk("sem_timeout_registra", 4'b0100, 2'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
